// File: rtl/cache_miss_ctrl.sv
// Data-cache miss handler: optional dirty-victim writeback, then a 4-beat line refill.
// Optional perf counters are compiled in with `define MISS_PERF_CNT_EN.
module cache_miss_ctrl #(
  parameter int MEM_ADDR_W = 28,
  parameter int DATA_W     = 128,
  parameter int BEATS      = 4,
  parameter int TAG_W      = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      miss_valid,
  output logic                      miss_ready,
  input  logic [MEM_ADDR_W-3:0]     miss_line_addr,
  input  logic                      miss_dirty,
  input  logic [MEM_ADDR_W-3:0]     victim_line_addr,
  input  logic [DATA_W*BEATS-1:0]   victim_line,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_rw,
  output logic [MEM_ADDR_W-1:0]     mem_req_addr,
  output logic                      mem_req_data_valid,
  input  logic                      mem_req_data_ready,
  output logic [DATA_W-1:0]         mem_req_data_bits,
  output logic [DATA_W/8-1:0]       mem_req_data_mask,
  input  logic                      mem_resp_valid,
  input  logic [DATA_W-1:0]         mem_resp_data,
  output logic                      refill_valid,
  output logic [1:0]                refill_beat,
  output logic [DATA_W-1:0]         refill_data,
  output logic                      miss_done
`ifdef MISS_PERF_CNT_EN
  ,
  output logic [31:0]               perf_refills,
  output logic [31:0]               perf_writebacks
`endif
);

  // Beat index is 2 bits wide and each beat maps onto one of four data SRAMs.
  if (BEATS != 4) begin : g_bad_beats
    $error("cache_miss_ctrl: BEATS must be 4");
  end
  if (TAG_W > MEM_ADDR_W - 2) begin : g_bad_tag
    $error("cache_miss_ctrl: TAG_W wider than line address");
  end

  localparam logic [1:0] LAST = 2'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_DATA, RF_REQ, RF_DATA, DONE} state_t;

  state_t                    state, state_n;
  logic [1:0]                beat;
  logic [MEM_ADDR_W-3:0]     line_q, victim_addr_q;
  logic [DATA_W*BEATS-1:0]   victim_q;

  logic wb_beat_acc, rf_beat_acc;
  assign wb_beat_acc = (state == WB_DATA) && mem_req_data_ready;
  assign rf_beat_acc = (state == RF_DATA) && mem_resp_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      beat          <= '0;
      line_q        <= '0;
      victim_addr_q <= '0;
      victim_q      <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && miss_valid) begin
        line_q        <= miss_line_addr;
        victim_addr_q <= victim_line_addr;
        victim_q      <= victim_line;
      end
      // beat wraps naturally from LAST back to 0 at the end of each burst
      if (state == WB_REQ && mem_req_ready) beat <= '0;
      else if (wb_beat_acc || rf_beat_acc)  beat <= beat + 2'd1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (miss_valid) state_n = miss_dirty ? WB_REQ : RF_REQ;
      WB_REQ:  if (mem_req_ready) state_n = WB_DATA;
      WB_DATA: if (wb_beat_acc && beat == LAST) state_n = RF_REQ;
      RF_REQ:  if (mem_req_ready) state_n = RF_DATA;
      RF_DATA: if (rf_beat_acc && beat == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    miss_ready         = (state == IDLE);
    mem_req_valid      = 1'b0;
    mem_req_rw         = 1'b0;
    mem_req_addr       = '0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;
    refill_valid       = 1'b0;
    refill_beat        = 2'd0;
    refill_data        = '0;
    miss_done          = (state == DONE);
    case (state)
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {victim_addr_q, 2'b00};
      end
      WB_DATA: begin
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = victim_q[beat*DATA_W +: DATA_W];
        mem_req_data_mask  = '1;
      end
      RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {line_q, 2'b00};
      end
      RF_DATA: begin
        refill_valid = mem_resp_valid;
        refill_beat  = beat;
        refill_data  = mem_resp_data;
      end
      default: ;
    endcase
  end

`ifdef MISS_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_refills    <= '0;
      perf_writebacks <= '0;
    end else begin
      if (state != DONE && state_n == DONE) perf_refills    <= perf_refills + 32'd1;
      if (state == WB_REQ && mem_req_ready) perf_writebacks <= perf_writebacks + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed self-checking bench for cache_miss_ctrl: clean/dirty misses, stalls, stray
// responses, mid-refill reset and (with MISS_PERF_CNT_EN) the perf counters.
module tb_cache_miss_ctrl;
  localparam int MA = 28, DW = 128, LA = 26;

  logic              clk = 1'b0;
  logic              reset;
  logic              miss_valid, miss_ready, miss_dirty;
  logic [LA-1:0]     miss_line_addr, victim_line_addr;
  logic [DW*4-1:0]   victim_line;
  logic              mem_req_valid, mem_req_ready, mem_req_rw;
  logic [MA-1:0]     mem_req_addr;
  logic              mem_req_data_valid, mem_req_data_ready;
  logic [DW-1:0]     mem_req_data_bits;
  logic [DW/8-1:0]   mem_req_data_mask;
  logic              mem_resp_valid;
  logic [DW-1:0]     mem_resp_data;
  logic              refill_valid;
  logic [1:0]        refill_beat;
  logic [DW-1:0]     refill_data;
  logic              miss_done;
`ifdef MISS_PERF_CNT_EN
  logic [31:0]       perf_refills, perf_writebacks;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_miss_ctrl dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_line_addr(miss_line_addr), .miss_dirty(miss_dirty),
    .victim_line_addr(victim_line_addr), .victim_line(victim_line),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .refill_valid(refill_valid), .refill_beat(refill_beat),
    .refill_data(refill_data), .miss_done(miss_done)
`ifdef MISS_PERF_CNT_EN
    , .perf_refills(perf_refills), .perf_writebacks(perf_writebacks)
`endif
  );

  function automatic logic [DW-1:0] pat_a(input int k);
    return {4{32'hA0A0_0000 + 32'(k)}};
  endfunction
  function automatic logic [DW-1:0] pat_d(input int k);
    return {4{32'hD0D0_0000 + 32'(k)}};
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({miss_ready, mem_req_valid, mem_req_data_valid, refill_valid, miss_done, mem_req_data_mask,
         mem_req_addr, mem_req_data_bits, refill_data, refill_beat} !== {1'b1, 4'b0, 16'h0, 28'h0, 128'h0, 128'h0, 2'd0}) begin
      errors++;
      $display("FAIL reset_state ready=%b rv=%b dv=%b fv=%b done=%b mask=%h addr=%h", miss_ready,
               mem_req_valid, mem_req_data_valid, refill_valid, miss_done, mem_req_data_mask, mem_req_addr);
    end
  endtask

  task automatic test_clean();
    miss_valid = 1; miss_dirty = 0; miss_line_addr = 26'h0123456; mem_req_ready = 1;
    @(negedge clk);
    checks++;
    if (miss_ready !== 1'b1) begin errors++; $display("FAIL clean_ready got=%b want=1", miss_ready); end
    cyc(); miss_valid = 0; miss_line_addr = '0;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data_valid} !== {1'b1, 1'b0, 28'h048D158, 1'b0}) begin
      errors++; $display("FAIL clean_rdreq v=%b rw=%b addr=%h want 1 0 048d158", mem_req_valid, mem_req_rw, mem_req_addr);
    end
    cyc();
    for (int k = 0; k < 4; k++) begin
      mem_resp_valid = 1; mem_resp_data = pat_a(k);
      @(negedge clk);
      checks++;
      if ({refill_valid, refill_beat, refill_data, mem_req_valid} !== {1'b1, 2'(k), pat_a(k), 1'b0}) begin
        errors++; $display("FAIL clean_refill%0d v=%b beat=%0d data=%h", k, refill_valid, refill_beat, refill_data);
      end
      cyc();
    end
    mem_resp_valid = 0;
    @(negedge clk);
    checks++;
    if ({miss_done, miss_ready, refill_valid} !== 3'b100) begin
      errors++; $display("FAIL clean_done done=%b ready=%b fv=%b want 1 0 0", miss_done, miss_ready, refill_valid);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({miss_done, miss_ready} !== 2'b01) begin
      errors++; $display("FAIL clean_idle done=%b ready=%b want 0 1", miss_done, miss_ready);
    end
    cyc();
  endtask

  task automatic test_dirty_stall();
    miss_valid = 1; miss_dirty = 1; miss_line_addr = 26'h1555555; victim_line_addr = 26'h0000010;
    victim_line = {pat_d(3), pat_d(2), pat_d(1), pat_d(0)};
    mem_req_ready = 1; mem_req_data_ready = 0;
    cyc();
    // scrub the inputs so the bench sees only the buffered copy
    miss_valid = 0; miss_line_addr = '0; victim_line_addr = '0; victim_line = '0;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data_valid} !== {1'b1, 1'b1, 28'h0000040, 1'b0}) begin
      errors++; $display("FAIL dirty_wrreq v=%b rw=%b addr=%h want 1 1 0000040", mem_req_valid, mem_req_rw, mem_req_addr);
    end
    cyc(); mem_req_ready = 0;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 3; w++) begin
        mem_req_data_ready = (w == 2);
        mem_resp_valid = (w == 0); mem_resp_data = pat_a(7);
        @(negedge clk);
        checks++;
        if ({mem_req_data_valid, mem_req_valid, mem_req_data_bits, mem_req_data_mask, refill_valid}
            !== {1'b1, 1'b0, pat_d(k), 16'hFFFF, 1'b0}) begin
          errors++; $display("FAIL dirty_wb%0d_%0d dv=%b rv=%b bits=%h mask=%h fv=%b", k, w,
                             mem_req_data_valid, mem_req_valid, mem_req_data_bits, mem_req_data_mask, refill_valid);
        end
        cyc();
      end
    end
    mem_resp_valid = 0; mem_req_data_ready = 0;
    for (int w = 0; w < 6; w++) begin
      mem_req_ready = (w == 5);
      @(negedge clk);
      checks++;
      if ({mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data_valid} !== {1'b1, 1'b0, 28'h5555554, 1'b0}) begin
        errors++; $display("FAIL stall_rdreq%0d v=%b rw=%b addr=%h want 1 0 5555554", w, mem_req_valid, mem_req_rw, mem_req_addr);
      end
      cyc();
    end
    for (int k = 0; k < 4; k++) begin
      mem_resp_valid = 1; mem_resp_data = pat_a(k + 4);
      @(negedge clk);
      checks++;
      if ({refill_valid, refill_beat, refill_data} !== {1'b1, 2'(k), pat_a(k + 4)}) begin
        errors++; $display("FAIL dirty_refill%0d v=%b beat=%0d data=%h", k, refill_valid, refill_beat, refill_data);
      end
      cyc();
    end
    mem_resp_valid = 0;
    @(negedge clk);
    checks++;
    if ({miss_done, miss_ready} !== 2'b10) begin
      errors++; $display("FAIL dirty_done done=%b ready=%b want 1 0", miss_done, miss_ready);
    end
    cyc();
  endtask

  task automatic test_stray_idle();
    mem_resp_valid = 1; mem_resp_data = pat_a(9);
    @(negedge clk);
    checks++;
    if ({refill_valid, refill_beat, refill_data, miss_ready} !== {1'b0, 2'd0, 128'h0, 1'b1}) begin
      errors++; $display("FAIL stray_idle fv=%b beat=%0d data=%h ready=%b", refill_valid, refill_beat, refill_data, miss_ready);
    end
    cyc(); mem_resp_valid = 0;
  endtask

  task automatic test_reset_mid();
    miss_valid = 1; miss_dirty = 0; miss_line_addr = 26'h0000777; mem_req_ready = 1;
    cyc(); miss_valid = 0;
    cyc();
    for (int k = 0; k < 2; k++) begin
      mem_resp_valid = 1; mem_resp_data = pat_a(k); cyc();
    end
    mem_resp_data = pat_a(2);
    @(negedge clk);
    checks++;
    if ({refill_valid, refill_beat} !== {1'b1, 2'd2}) begin
      errors++; $display("FAIL mid_beat2 v=%b beat=%0d want 1 2", refill_valid, refill_beat);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({miss_ready, mem_req_valid, mem_req_data_valid, refill_valid, miss_done, refill_beat, mem_req_addr, refill_data}
        !== {1'b1, 4'b0, 2'd0, 28'h0, 128'h0}) begin
      errors++; $display("FAIL mid_reset ready=%b rv=%b fv=%b beat=%0d addr=%h", miss_ready, mem_req_valid,
                         refill_valid, refill_beat, mem_req_addr);
    end
    cyc(); reset = 0; mem_resp_valid = 0;
    miss_valid = 1; miss_line_addr = 26'h0000888;
    cyc(); miss_valid = 0;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_rw, mem_req_addr} !== {1'b1, 1'b0, 28'h0002220}) begin
      errors++; $display("FAIL post_reset_req v=%b rw=%b addr=%h want 1 0 0002220", mem_req_valid, mem_req_rw, mem_req_addr);
    end
    cyc();
    mem_resp_valid = 1; mem_resp_data = pat_a(5);
    @(negedge clk);
    checks++;
    if ({refill_valid, refill_beat, refill_data} !== {1'b1, 2'd0, pat_a(5)}) begin
      errors++; $display("FAIL post_reset_beat0 v=%b beat=%0d data=%h", refill_valid, refill_beat, refill_data);
    end
    repeat (4) cyc();
    mem_resp_valid = 0;
    @(negedge clk);
    checks++;
    if (miss_done !== 1'b1) begin errors++; $display("FAIL post_reset_done got=%b want=1", miss_done); end
    cyc();
  endtask

`ifdef MISS_PERF_CNT_EN
  task automatic run_miss(input logic dirty);
    miss_valid = 1; miss_dirty = dirty; mem_req_ready = 1; mem_req_data_ready = 1;
    cyc(); miss_valid = 0;
    if (dirty) repeat (5) cyc();
    cyc();
    mem_resp_valid = 1; repeat (4) cyc();
    mem_resp_valid = 0; cyc();
  endtask

  task automatic test_perf();
    reset = 1; cyc(); reset = 0;
    repeat (3) run_miss(1'b0);
    repeat (2) run_miss(1'b1);
    @(negedge clk);
    checks++;
    if ({perf_refills, perf_writebacks, miss_ready} !== {32'd5, 32'd2, 1'b1}) begin
      errors++; $display("FAIL perf refills=%0d wbs=%0d ready=%b want 5 2 1", perf_refills, perf_writebacks, miss_ready);
    end
    cyc();
  endtask
`endif

  initial begin
    reset = 1; miss_valid = 0; miss_dirty = 0; miss_line_addr = '0; victim_line_addr = '0;
    victim_line = '0; mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    cyc();
    test_reset();
    cyc(); reset = 0;
    test_clean();
    test_dirty_stall();
    test_stray_idle();
    test_reset_mid();
`ifdef MISS_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
